rnd_harvest_ctrl: RTL

Sequencer for the free-running 16-bit random bank (RND_N cells sharing one freeze gate and an address-selected 16-bit read mux).
- Lets the bank run, freezes it, and walks the read address across every cell.
- Folds each settled sample into a 16-bit pool.
- Presents the pool on a valid/ready output port, with a health flag and a harvest counter.
- Sits between the bank and whatever consumes random words (pin mux or downstream logic).

---
 rtl/rnd_harvest_ctrl_if.sv | 37 +++
 rtl/rnd_harvest_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rnd_harvest_ctrl_if.sv
// Bank-side and consumer-side signals of the random harvest controller.
// master = controller, slave = bank mux plus word consumer.
// Backpressure: out_ready stalls the controller while it holds a finished word.
interface rnd_harvest_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              freeze_o;
  logic [ADDR_W-1:0] addr_o;
  logic [15:0]       rand_i;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_stuck;
  logic [7:0]        out_count;

  modport master (
    output freeze_o,
    output addr_o,
    input  rand_i,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_stuck,
    output out_count
  );

  modport slave (
    input  freeze_o,
    input  addr_o,
    output rand_i,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_stuck,
    input  out_count
  );
endinterface

// File: rtl/rnd_harvest_ctrl.sv
// Runs, freezes and scans the random bank, folding every cell into a 16-bit pool word.
// Latency: RUN_CYCLES + RND_N*SETTLE clocks from enable to out_valid; all outputs registered.
// Backpressure: the finished word and all bank controls hold in OUT until out_ready.
module rnd_harvest_ctrl #(
  parameter int RND_N      = 34,
  parameter int ADDR_W     = $clog2(RND_N),
  parameter int RUN_CYCLES = 16,
  parameter int SETTLE     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               busy,
  rnd_harvest_ctrl_if.master bus
);

  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int SET_W = $clog2(SETTLE);

  localparam logic [RUN_W-1:0]  RUN_LOAD    = RUN_W'(RUN_CYCLES - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(RND_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state;
  logic [RUN_W-1:0]  run_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              freeze_q;
  logic [15:0]       pool;
  logic [15:0]       ref_word;
  logic              stuck_acc;
  logic [15:0]       data_q;
  logic              stuck_q;
  logic [7:0]        count_q;
  logic              valid_q;

  logic [15:0] pool_nxt;
  logic        first_sample;
  logic        stuck_nxt;

  // The first sample is the reference; every later one is compared against it.
  assign pool_nxt     = {pool[14:0], pool[15]} ^ bus.rand_i;
  assign first_sample = (addr_q == '0);
  assign stuck_nxt    = first_sample ? 1'b0 : (stuck_acc | (bus.rand_i != ref_word));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_cnt    <= '0;
      settle_cnt <= '0;
      addr_q     <= '0;
      freeze_q   <= 1'b0;
      pool       <= '0;
      ref_word   <= '0;
      stuck_acc  <= 1'b0;
      data_q     <= '0;
      stuck_q    <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          freeze_q <= 1'b0;
          addr_q   <= '0;
          if (enable) begin
            state   <= RUN;
            run_cnt <= RUN_LOAD;
            busy    <= 1'b1;
          end
        end

        RUN: begin
          if (run_cnt == '0) begin
            state      <= HOLD;
            freeze_q   <= 1'b1;
            addr_q     <= '0;
            pool       <= '0;
            settle_cnt <= SETTLE_LOAD;
          end else begin
            run_cnt <= run_cnt - 1'b1;
          end
        end

        HOLD: begin
          if (settle_cnt == '0) begin
            pool      <= pool_nxt;
            stuck_acc <= stuck_nxt;
            if (first_sample) begin
              ref_word <= bus.rand_i;
            end
            if (addr_q == ADDR_LAST) begin
              state    <= OUT;
              freeze_q <= 1'b0;
              addr_q   <= '0;
              data_q   <= pool_nxt;
              stuck_q  <= ~stuck_nxt;
              count_q  <= count_q + 8'd1;
              valid_q  <= 1'b1;
            end else begin
              addr_q     <= addr_q + 1'b1;
              settle_cnt <= SETTLE_LOAD;
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        OUT: begin
          freeze_q <= 1'b0;
          addr_q   <= '0;
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (enable) begin
              state   <= RUN;
              run_cnt <= RUN_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state    <= IDLE;
          freeze_q <= 1'b0;
          addr_q   <= '0;
          valid_q  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freeze_o  = freeze_q;
  assign bus.addr_o    = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_stuck = stuck_q;
  assign bus.out_count = count_q;

endmodule
